stopwatch_time_counter: RTL
===========================

# stopwatch_time_counter

Timekeeping datapath driven by the stopwatch control FSM's `enable`, `clear` and `run_md` outputs. It divides the system clock into a 100 Hz tick and advances a cascaded centisecond/second/minute/hour counter. It presents the counter value and a run-mode-selected display pair to the FND display driver. It holds no control state of its own beyond an optional lap-freeze latch.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 100: count rate in Hz. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high.
- `enable`  input  1  level; counting is allowed while high.
- `clear`  input  1  level; synchronous zeroing of all counters.
- `run_md`  input  1  display select: 0 = sec:csec, 1 = hour:min.
- `lap`  input  1  single-cycle pulse; toggles the lap freeze. Ignored unless `STOPWATCH_LAP_EN` is defined.
- `csec`  output  7  centiseconds, 0–99.
- `sec`  output  6  seconds, 0–59.
- `min`  output  6  minutes, 0–59.
- `hour`  output  5  hours, 0–23.
- `disp_hi`  output  7  display upper pair, zero-extended.
- `disp_lo`  output  7  display lower pair, zero-extended.
- `tick`  output  1  one-cycle pulse on each count advance.
- `frozen`  output  1  lap freeze active.

## Operation
- **Prescaler**
  - Width is `$clog2(DIV)`.
  - Increments each cycle while `enable` = 1 and `clear` = 0.
  - On reaching `DIV-1` it wraps to 0 and asserts the internal tick.
  - While `enable` = 0 it holds its value, so a paused fraction resumes exactly.
- **Cascade**, on each tick:
  - `csec` +1. At 99 it wraps to 0 and carries to `sec`.
  - `sec` wraps 59 → 0 and carries to `min`.
  - `min` wraps 59 → 0 and carries to `hour`.
  - `hour` wraps 23 → 0 with no carry out. 23:59:59.99 → 00:00:00.00.
- **Clear priority**
  - `clear` = 1 forces prescaler, all four counters, `tick` and `frozen` to 0 on the next edge.
  - `clear` overrides `enable` and a coincident tick.
- **Enable/clear overlap**: `enable` and `clear` both high is not produced by the FSM. If it occurs, `clear` wins.
- **Display mux** (combinational from registers):
  - `run_md` = 0: `disp_hi` = sec, `disp_lo` = csec.
  - `run_md` = 1: `disp_hi` = hour, `disp_lo` = min.
- **Mode changes**: `run_md` may change in any cycle. It affects only the mux, never the counters.
- **Source of display values**: `csec`/`sec`/`min`/`hour` always show the live counters. The display mux uses lap values when `frozen` = 1.

## Timing
- **Reset values**: all outputs 0. Prescaler 0. Lap registers 0.
- **Tick timing**: `tick` is registered. It is high in the cycle after the prescaler held `DIV-1` with `enable` = 1. Counters update on that same edge, so `tick` and the new count are visible together.
- **Enable latency**: `enable` rising at edge N gives the first tick after exactly `DIV` enabled cycles from a zero prescaler.
- **Clear latency**: 1 cycle.
- **Mux latency**: 0 cycles (combinational from registers).
- **Run rate**: with `enable` held high, exactly one tick per `DIV` cycles. Never two ticks in consecutive cycles.
- **Reset mid-count**: returns everything to 0 immediately (asynchronous). Counting restarts from 0 once reset is released and `enable` = 1.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- **Defined**:
  - A `lap` pulse while `frozen` = 0 captures all four counters into lap registers on that edge and sets `frozen`.
  - A `lap` pulse while `frozen` = 1 clears `frozen`.
  - While frozen, the display mux reads lap registers; live counters keep running.
  - `lap` coincident with `clear`: `clear` wins and `frozen` = 0.
- **Undefined**:
  - No lap registers are built.
  - `lap` is ignored and `frozen` is tied to 0.
  - The display mux always reads the live counters.

## Test plan
- **Prescale**: `CLK_HZ`=1000, `TICK_HZ`=100 (`DIV`=10); reset, then `enable`=1 for 25 cycles → exactly 2 `tick` pulses, on cycles 11 and 21 after enable; `csec`=2.
- **Pause/resume**: enable for 15 cycles, `enable`=0 for 50 cycles, enable again → next tick after 5 further enabled cycles; `csec` unchanged during the pause.
- **Full wrap**: preset by counting (or force) to 23:59:59.99; one tick → all of `hour`/`min`/`sec`/`csec` = 0 in the same cycle as `tick`.
- **Clear dominance**: `clear`=1 with `enable`=1 on the cycle the prescaler = 9 → no tick, counters and prescaler 0 next cycle. Separately, `run_md` toggle at 00:01:02.03 → `disp_hi`/`disp_lo` switch 2/3 ↔ 0/1 with no counter change.
- **Lap** (`STOPWATCH_LAP_EN` defined): `lap` at `csec`=37 → `disp_lo` stays 37 while `csec` advances; second `lap` → `disp_lo` tracks `csec`. Without the macro, `lap` has no effect and `frozen`=0.
- **Async reset**: assert `reset` mid-count between clock edges → all outputs 0 immediately, not at the next edge.

Source files
------------

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timekeeping datapath: 100 Hz prescaler, cascaded csec/sec/min/hour counter, display mux.
// Optional lap-freeze latch built only when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       clear,
   input  logic       run_md,
   input  logic       lap,
   output logic [6:0] csec,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic [6:0] disp_hi,
   output logic [6:0] disp_lo,
   output logic       tick,
   output logic       frozen
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] presc;
   logic          presc_end;
   logic          adv;
   logic          tick_q;
   logic [6:0]    csec_q;
   logic [5:0]    sec_q;
   logic [5:0]    min_q;
   logic [4:0]    hour_q;
   logic [6:0]    src_csec;
   logic [5:0]    src_sec;
   logic [5:0]    src_min;
   logic [4:0]    src_hour;

   assign presc_end = (presc == PW'(DIV - 1));
   assign adv       = enable && !clear && presc_end;

   // Prescaler holds while enable is low so a paused fraction resumes exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc  <= '0;
         tick_q <= 1'b0;
      end else if (clear) begin
         presc  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= adv;
         if (enable) begin
            presc <= presc_end ? '0 : presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csec_q <= '0;
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= '0;
      end else if (clear) begin
         csec_q <= '0;
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= '0;
      end else if (adv) begin
         if (csec_q == 7'd99) begin
            csec_q <= '0;
            if (sec_q == 6'd59) begin
               sec_q <= '0;
               if (min_q == 6'd59) begin
                  min_q  <= '0;
                  hour_q <= (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
               end else begin
                  min_q <= min_q + 6'd1;
               end
            end else begin
               sec_q <= sec_q + 6'd1;
            end
         end else begin
            csec_q <= csec_q + 7'd1;
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [6:0] lap_csec;
   logic [5:0] lap_sec;
   logic [5:0] lap_min;
   logic [4:0] lap_hour;
   logic       frozen_q;

   // Capture takes the pre-edge live value, i.e. what the display showed when lap was pressed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lap_csec <= '0;
         lap_sec  <= '0;
         lap_min  <= '0;
         lap_hour <= '0;
         frozen_q <= 1'b0;
      end else if (clear) begin
         frozen_q <= 1'b0;
      end else if (lap) begin
         if (!frozen_q) begin
            lap_csec <= csec_q;
            lap_sec  <= sec_q;
            lap_min  <= min_q;
            lap_hour <= hour_q;
            frozen_q <= 1'b1;
         end else begin
            frozen_q <= 1'b0;
         end
      end
   end

   assign frozen   = frozen_q;
   assign src_csec = frozen_q ? lap_csec : csec_q;
   assign src_sec  = frozen_q ? lap_sec  : sec_q;
   assign src_min  = frozen_q ? lap_min  : min_q;
   assign src_hour = frozen_q ? lap_hour : hour_q;
`else
   // lap is consumed but has no effect when the lap feature is not built.
   assign frozen   = lap & 1'b0;
   assign src_csec = csec_q;
   assign src_sec  = sec_q;
   assign src_min  = min_q;
   assign src_hour = hour_q;
`endif

   always_comb begin
      disp_hi = '0;
      disp_lo = '0;
      if (run_md) begin
         disp_hi = {2'b00, src_hour};
         disp_lo = {1'b0, src_min};
      end else begin
         disp_hi = {1'b0, src_sec};
         disp_lo = src_csec;
      end
   end

   assign tick = tick_q;
   assign csec = csec_q;
   assign sec  = sec_q;
   assign min  = min_q;
   assign hour = hour_q;

endmodule
